// File: rtl/fifo_write_arbiter_if.sv
// Producer-side bus of the FIFO write arbiter.
// The master modport belongs to the producers and the FIFO-full source.
// The slave modport belongs to the arbiter.
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int width   = 4
) ();
   localparam int OW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*width-1:0] req_data;
   logic                     full;
   logic [NUM_REQ-1:0]       grant;
   logic                     write;
   logic [width-1:0]         wdata;
   logic [OW-1:0]            owner;
   logic                     busy;
   logic [3:0]               beat_cnt;

   modport master (
      output req, req_data, full,
      input  grant, write, wdata, owner, busy, beat_cnt
   );

   modport slave (
      input  req, req_data, full,
      output grant, write, wdata, owner, busy, beat_cnt
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the single FIFO write port.
// One producer owns the port for up to max_burst accepted writes.
// Ownership then rotates, and the owner stalls while the FIFO is full.
// grant, owner, busy and beat_cnt are registered.
// write and wdata are decoded combinationally from the registered owner,
// so a change on full takes effect in the same cycle.
module fifo_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int width     = 4,
   parameter int max_burst = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_write_arbiter_if.slave  bus
);
   localparam int          OW = $clog2(NUM_REQ);
   localparam logic [4:0]  MB = 5'(max_burst);

   typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

   state_t               state;
   logic [NUM_REQ-1:0]   grant;
   logic [OW-1:0]        owner;
   logic [OW-1:0]        last_owner;
   logic                 busy;
   logic [3:0]           beat_cnt;

   logic                 write;
   logic [width-1:0]     sel_data;
   logic [width-1:0]     wdata;
   logic [OW:0]          pick_all;
   logic [OW:0]          pick_ex;
   logic                 last_beat;

   // First requester after 'last' in circular order, returned as {found, index}.
   function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [OW-1:0] last);
      logic          found;
      logic [OW-1:0] sel;
      logic [OW-1:0] idx;
      found = 1'b0;
      sel   = {OW{1'b0}};
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = OW'((int'(last) + k) % NUM_REQ);
         if (!found && r[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      return {found, sel};
   endfunction

   // Convert an index into a one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] to_onehot(input logic [OW-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = {NUM_REQ{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Search over all requesters (idle or owner release).
   assign pick_all  = rr_pick(bus.req, last_owner);
   // Search that skips the owner (burst expiry).
   assign pick_ex   = rr_pick(bus.req & ~to_onehot(owner), last_owner);
   assign last_beat = (({1'b0, beat_cnt} + 5'd1) >= MB);

   // Select the owner's data word and decode the write strobe.
   always_comb begin
      sel_data = {width{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_data = (owner == OW'(i)) ? bus.req_data[i*width +: width] : sel_data;
      end
      write = busy & bus.req[owner] & ~bus.full;
      wdata = write ? sel_data : {width{1'b0}};
   end

   // Ownership FSM: grant on request, count beats, rotate on expiry or release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant      <= {NUM_REQ{1'b0}};
         owner      <= {OW{1'b0}};
         last_owner <= OW'(NUM_REQ - 1);
         busy       <= 1'b0;
         beat_cnt   <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               beat_cnt <= 4'd0;
               if (pick_all[OW]) begin
                  state      <= OWN;
                  grant      <= to_onehot(pick_all[OW-1:0]);
                  owner      <= pick_all[OW-1:0];
                  last_owner <= pick_all[OW-1:0];
                  busy       <= 1'b1;
               end else begin
                  state <= IDLE;
                  grant <= {NUM_REQ{1'b0}};
                  busy  <= 1'b0;
               end
            end
            OWN: begin
               if (!bus.req[owner]) begin
                  // Owner released the port: hand it to the next requester.
                  beat_cnt <= 4'd0;
                  if (pick_all[OW]) begin
                     grant      <= to_onehot(pick_all[OW-1:0]);
                     owner      <= pick_all[OW-1:0];
                     last_owner <= pick_all[OW-1:0];
                  end else begin
                     state <= IDLE;
                     grant <= {NUM_REQ{1'b0}};
                     busy  <= 1'b0;
                  end
               end else if (write) begin
                  if (!last_beat) begin
                     beat_cnt <= beat_cnt + 4'd1;
                  end else begin
                     // Burst expired: prefer any other requester.
                     // Otherwise the owner keeps the port with a fresh count.
                     beat_cnt <= 4'd0;
                     if (pick_ex[OW]) begin
                        grant      <= to_onehot(pick_ex[OW-1:0]);
                        owner      <= pick_ex[OW-1:0];
                        last_owner <= pick_ex[OW-1:0];
                     end else begin
                        grant <= to_onehot(owner);
                     end
                  end
               end else begin
                  // FIFO full: hold ownership and count.
                  beat_cnt <= beat_cnt;
               end
            end
            default: begin
               state    <= IDLE;
               grant    <= {NUM_REQ{1'b0}};
               busy     <= 1'b0;
               beat_cnt <= 4'd0;
            end
         endcase
      end
   end

   assign bus.grant    = grant;
   assign bus.owner    = owner;
   assign bus.busy     = busy;
   assign bus.beat_cnt = beat_cnt;
   assign bus.write    = write;
   assign bus.wdata    = wdata;
endmodule
